// File: rtl/parallel_twiddle_mul_fft4.sv
// parallel_twiddle_mul_fft4
//   Final radix-4 stage of an 8192-point FFT built as 2048 x 4. Each clock one
//   group of four complex samples x0..x3 with group label k is accepted; sample
//   n is rotated by W8192^(k*n), a 4-point DFT is formed, and the four results
//   are scaled by an arithmetic shift and wrapped to MSB_CUTOFF+1 bits.
//   Fixed latency of 6 clocks (7 register ranks counting the input capture).
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset, clears every register
//   valid          input group valid
//   lable[10:0]    group label k (0..2047)
//   xN_r / xN_i    signed DATA_WIDTH input samples, n = 0..3
//   yM_r / yM_i    signed MSB_CUTOFF+1 output bins, m = 0..3
//   index[10:0]    lable aligned with y
//   ready          valid aligned with y
module parallel_twiddle_mul_fft4 #(
  parameter int DATA_WIDTH = 21,
  parameter int TWID_WIDTH = 16,
  parameter int MSB_CUTOFF = 26,
  parameter int LSB_CUTOFF = 12,
  parameter int SHIFT      = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid,
  input  logic [10:0]                  lable,
  input  logic signed [DATA_WIDTH-1:0] x0_r,
  input  logic signed [DATA_WIDTH-1:0] x0_i,
  input  logic signed [DATA_WIDTH-1:0] x1_r,
  input  logic signed [DATA_WIDTH-1:0] x1_i,
  input  logic signed [DATA_WIDTH-1:0] x2_r,
  input  logic signed [DATA_WIDTH-1:0] x2_i,
  input  logic signed [DATA_WIDTH-1:0] x3_r,
  input  logic signed [DATA_WIDTH-1:0] x3_i,
  output logic signed [MSB_CUTOFF:0]   y0_r,
  output logic signed [MSB_CUTOFF:0]   y0_i,
  output logic signed [MSB_CUTOFF:0]   y1_r,
  output logic signed [MSB_CUTOFF:0]   y1_i,
  output logic signed [MSB_CUTOFF:0]   y2_r,
  output logic signed [MSB_CUTOFF:0]   y2_i,
  output logic signed [MSB_CUTOFF:0]   y3_r,
  output logic signed [MSB_CUTOFF:0]   y3_i,
  output logic [10:0]                  index,
  output logic                         ready
);

  localparam int  PROD_W = DATA_WIDTH + TWID_WIDTH;  // one real product
  localparam int  PW     = PROD_W + 1;               // complex product component
  localparam int  BW     = PW + 1;                   // first butterfly level
  localparam int  SW     = PW + 2;                   // final butterfly sums
  localparam int  OW     = MSB_CUTOFF + 1;
  localparam int  EW     = 13;                       // exponent mod 8192
  localparam int  QN     = 2048;                     // quarter-wave table depth
  localparam int  TMAX   = 2**(TWID_WIDTH-1) - 1;
  localparam real TWO_PI = 6.283185307179586476;

  // Quarter-wave twiddle entry: round half away from zero, symmetric saturation.
  // Symmetric rounding/saturation makes quadrant rotation of this table
  // bit-identical to evaluating cos/sin directly over the full circle.
  function automatic logic signed [TWID_WIDTH-1:0] tw_quarter(input int e, input bit want_sin);
    real ang;
    real v;
    int  r;
    ang = TWO_PI * real'(e) / 8192.0;
    v   = (want_sin ? $sin(ang) : $cos(ang)) * (2.0 ** SHIFT);
    r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    if (r > TMAX)       r = TMAX;
    else if (r < -TMAX) r = -TMAX;
    return TWID_WIDTH'(r);
  endfunction

  // Floor shift then wrap to the output width.
  function automatic logic signed [OW-1:0] scale_out(input logic signed [SW-1:0] s);
    return OW'(s >>> LSB_CUTOFF);
  endfunction

  logic signed [TWID_WIDTH-1:0] cos_rom [QN];
  logic signed [TWID_WIDTH-1:0] sin_rom [QN];

  for (genvar g = 0; g < QN; g++) begin : g_rom
    assign cos_rom[g] = tw_quarter(g, 1'b0);
    assign sin_rom[g] = tw_quarter(g, 1'b1);
  end

  logic signed [DATA_WIDTH-1:0] xr_in [4];
  logic signed [DATA_WIDTH-1:0] xi_in [4];
  logic [EW-1:0]                e_in  [4];

  // k*n never exceeds 3*2047 = 6141, so no modulo is needed.
  always_comb begin
    xr_in[0] = x0_r;  xi_in[0] = x0_i;
    xr_in[1] = x1_r;  xi_in[1] = x1_i;
    xr_in[2] = x2_r;  xi_in[2] = x2_i;
    xr_in[3] = x3_r;  xi_in[3] = x3_i;
    e_in[0]  = '0;
    e_in[1]  = EW'(lable);
    e_in[2]  = EW'({lable, 1'b0});
    e_in[3]  = EW'(lable) + EW'({lable, 1'b0});
  end

  logic signed [DATA_WIDTH-1:0] xr_p1_q [4], xi_p1_q [4];
  logic signed [DATA_WIDTH-1:0] xr_p2_q [4], xi_p2_q [4];
  logic signed [DATA_WIDTH-1:0] xr_p3_q [4], xi_p3_q [4];
  logic [EW-1:0]                e_p1_q  [4];
  logic signed [TWID_WIDTH-1:0] c_p2_q  [4], s_p2_q [4];
  logic [1:0]                   quad_p2_q [4];
  logic signed [TWID_WIDTH-1:0] wr_d    [4], wi_d   [4];
  logic signed [TWID_WIDTH-1:0] wr_p3_q [4], wi_p3_q [4];
  logic signed [PROD_W-1:0]     rr_p4_q [4], ii_p4_q [4], ri_p4_q [4], ir_p4_q [4];
  logic signed [PW-1:0]         pr_p5_q [4], pi_p5_q [4];
  logic signed [BW-1:0]         ar_p6_q, ai_p6_q, br_p6_q, bi_p6_q;
  logic signed [BW-1:0]         cr_p6_q, ci_p6_q, dr_p6_q, di_p6_q;
  logic signed [OW-1:0]         yr_p7_q [4], yi_p7_q [4];
  logic [6:0]                   vld_pipe_q;
  logic [10:0]                  lbl_pipe_q [7];

  // Twiddle quadrant rotation: each quadrant step multiplies by -j.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      wr_d[n] = c_p2_q[n];
      wi_d[n] = -s_p2_q[n];
      case (quad_p2_q[n])
        2'd1:    begin wr_d[n] = -s_p2_q[n]; wi_d[n] = -c_p2_q[n]; end
        2'd2:    begin wr_d[n] = -c_p2_q[n]; wi_d[n] =  s_p2_q[n]; end
        2'd3:    begin wr_d[n] =  s_p2_q[n]; wi_d[n] =  c_p2_q[n]; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        xr_p1_q[n] <= '0;  xi_p1_q[n] <= '0;  e_p1_q[n]    <= '0;
        xr_p2_q[n] <= '0;  xi_p2_q[n] <= '0;  quad_p2_q[n] <= '0;
        c_p2_q[n]  <= '0;  s_p2_q[n]  <= '0;
        xr_p3_q[n] <= '0;  xi_p3_q[n] <= '0;
        wr_p3_q[n] <= '0;  wi_p3_q[n] <= '0;
        rr_p4_q[n] <= '0;  ii_p4_q[n] <= '0;  ri_p4_q[n] <= '0;  ir_p4_q[n] <= '0;
        pr_p5_q[n] <= '0;  pi_p5_q[n] <= '0;
        yr_p7_q[n] <= '0;  yi_p7_q[n] <= '0;
      end
      ar_p6_q <= '0;  ai_p6_q <= '0;  br_p6_q <= '0;  bi_p6_q <= '0;
      cr_p6_q <= '0;  ci_p6_q <= '0;  dr_p6_q <= '0;  di_p6_q <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        // ---- p1: capture samples and twiddle exponents ----
        xr_p1_q[n]   <= xr_in[n];
        xi_p1_q[n]   <= xi_in[n];
        e_p1_q[n]    <= e_in[n];
        // ---- p2: quarter-wave table read ----
        xr_p2_q[n]   <= xr_p1_q[n];
        xi_p2_q[n]   <= xi_p1_q[n];
        c_p2_q[n]    <= cos_rom[e_p1_q[n][10:0]];
        s_p2_q[n]    <= sin_rom[e_p1_q[n][10:0]];
        quad_p2_q[n] <= e_p1_q[n][12:11];
        // ---- p3: full-circle twiddle ----
        xr_p3_q[n]   <= xr_p2_q[n];
        xi_p3_q[n]   <= xi_p2_q[n];
        wr_p3_q[n]   <= wr_d[n];
        wi_p3_q[n]   <= wi_d[n];
        // ---- p4: four real products per sample ----
        rr_p4_q[n]   <= PROD_W'(xr_p3_q[n]) * PROD_W'(wr_p3_q[n]);
        ii_p4_q[n]   <= PROD_W'(xi_p3_q[n]) * PROD_W'(wi_p3_q[n]);
        ri_p4_q[n]   <= PROD_W'(xr_p3_q[n]) * PROD_W'(wi_p3_q[n]);
        ir_p4_q[n]   <= PROD_W'(xi_p3_q[n]) * PROD_W'(wr_p3_q[n]);
        // ---- p5: complex product p_n ----
        pr_p5_q[n]   <= PW'(rr_p4_q[n]) - PW'(ii_p4_q[n]);
        pi_p5_q[n]   <= PW'(ri_p4_q[n]) + PW'(ir_p4_q[n]);
      end
      // ---- p6: first butterfly level, a/b from p0,p2 and c/d from p1,p3 ----
      ar_p6_q <= BW'(pr_p5_q[0]) + BW'(pr_p5_q[2]);
      ai_p6_q <= BW'(pi_p5_q[0]) + BW'(pi_p5_q[2]);
      br_p6_q <= BW'(pr_p5_q[0]) - BW'(pr_p5_q[2]);
      bi_p6_q <= BW'(pi_p5_q[0]) - BW'(pi_p5_q[2]);
      cr_p6_q <= BW'(pr_p5_q[1]) + BW'(pr_p5_q[3]);
      ci_p6_q <= BW'(pi_p5_q[1]) + BW'(pi_p5_q[3]);
      dr_p6_q <= BW'(pr_p5_q[1]) - BW'(pr_p5_q[3]);
      di_p6_q <= BW'(pi_p5_q[1]) - BW'(pi_p5_q[3]);
      // ---- p7: second level (y1 = b - j*d, y3 = b + j*d) and scaling ----
      yr_p7_q[0] <= scale_out(SW'(ar_p6_q) + SW'(cr_p6_q));
      yi_p7_q[0] <= scale_out(SW'(ai_p6_q) + SW'(ci_p6_q));
      yr_p7_q[1] <= scale_out(SW'(br_p6_q) + SW'(di_p6_q));
      yi_p7_q[1] <= scale_out(SW'(bi_p6_q) - SW'(dr_p6_q));
      yr_p7_q[2] <= scale_out(SW'(ar_p6_q) - SW'(cr_p6_q));
      yi_p7_q[2] <= scale_out(SW'(ai_p6_q) - SW'(ci_p6_q));
      yr_p7_q[3] <= scale_out(SW'(br_p6_q) - SW'(di_p6_q));
      yi_p7_q[3] <= scale_out(SW'(bi_p6_q) + SW'(dr_p6_q));
    end
  end

  // Control travels beside the data through the same seven ranks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      for (int i = 0; i < 7; i++) lbl_pipe_q[i] <= '0;
    end else begin
      vld_pipe_q    <= {vld_pipe_q[5:0], valid};
      lbl_pipe_q[0] <= lable;
      for (int i = 1; i < 7; i++) lbl_pipe_q[i] <= lbl_pipe_q[i-1];
    end
  end

  assign y0_r  = yr_p7_q[0];
  assign y0_i  = yi_p7_q[0];
  assign y1_r  = yr_p7_q[1];
  assign y1_i  = yi_p7_q[1];
  assign y2_r  = yr_p7_q[2];
  assign y2_i  = yi_p7_q[2];
  assign y3_r  = yr_p7_q[3];
  assign y3_i  = yi_p7_q[3];
  assign index = lbl_pipe_q[6];
  assign ready = vld_pipe_q[6];

endmodule

// File: tb/tb_parallel_twiddle_mul_fft4.sv
`timescale 1ns/1ps
module tb_parallel_twiddle_mul_fft4;

  localparam int DW   = 21;
  localparam int TW   = 16;
  localparam int LSB  = 12;
  localparam int SH   = 15;
  localparam int OW   = 27;
  localparam int TMAX = 2**(TW-1) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic valid = 1'b0;
  logic [10:0] lable = '0;
  logic signed [DW-1:0] x0_r = '0, x0_i = '0, x1_r = '0, x1_i = '0;
  logic signed [DW-1:0] x2_r = '0, x2_i = '0, x3_r = '0, x3_i = '0;
  logic signed [OW-1:0] y0_r, y0_i, y1_r, y1_i, y2_r, y2_i, y3_r, y3_i;
  logic [10:0] index;
  logic ready;

  parallel_twiddle_mul_fft4 dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .lable(lable),
    .x0_r(x0_r), .x0_i(x0_i), .x1_r(x1_r), .x1_i(x1_i),
    .x2_r(x2_r), .x2_i(x2_i), .x3_r(x3_r), .x3_i(x3_i),
    .y0_r(y0_r), .y0_i(y0_i), .y1_r(y1_r), .y1_i(y1_i),
    .y2_r(y2_r), .y2_i(y2_i), .y3_r(y3_r), .y3_i(y3_i),
    .index(index), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][OW-1:0] yr;
    logic [3:0][OW-1:0] yi;
    logic [10:0]        idx;
    int                 cyc;
  } exp_t;

  exp_t   sb[$];
  int     cyc = 0;
  int     n_chk = 0;
  int     n_bad = 0;
  longint sxr[4];
  longint sxi[4];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  function automatic longint rnd_sat(input real v);
    longint r;
    r = (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(0.5 - v));
    if (r > TMAX)  r = TMAX;
    if (r < -TMAX) r = -TMAX;
    return r;
  endfunction

  // Reference: y_m = sum_n x_n * W8192^(k*n) * (-j)^(n*m), floored and wrapped.
  function automatic exp_t model(input int k);
    exp_t   e;
    longint wr, wi, pr, pi, sr, si, t;
    real    ang;
    for (int m = 0; m < 4; m++) begin
      sr = 0;
      si = 0;
      for (int n = 0; n < 4; n++) begin
        ang = 2.0 * 3.14159265358979323846 * real'((k * n) % 8192) / 8192.0;
        wr  = rnd_sat($cos(ang) * real'(1 << SH));
        wi  = -rnd_sat($sin(ang) * real'(1 << SH));
        pr  = sxr[n] * wr - sxi[n] * wi;
        pi  = sxr[n] * wi + sxi[n] * wr;
        case ((n * m) % 4)
          0: begin sr += pr; si += pi; end
          1: begin sr += pi; si -= pr; end
          2: begin sr -= pr; si -= pi; end
          default: begin sr -= pi; si += pr; end
        endcase
      end
      t = sr >>> LSB;
      e.yr[m] = t[OW-1:0];
      t = si >>> LSB;
      e.yi[m] = t[OW-1:0];
    end
    e.idx = 11'(k);
    e.cyc = 0;
    return e;
  endfunction

  task automatic rand_x(input bit extreme);
    logic signed [DW-1:0] t;
    for (int n = 0; n < 4; n++) begin
      t = extreme ? ($urandom_range(0, 1) ? DW'(2**(DW-1) - 1) : DW'(-(2**(DW-1)))) : DW'($urandom);
      sxr[n] = t;
      t = extreme ? ($urandom_range(0, 1) ? DW'(2**(DW-1) - 1) : DW'(-(2**(DW-1)))) : DW'($urandom);
      sxi[n] = t;
    end
  endtask

  task automatic zero_x();
    for (int n = 0; n < 4; n++) begin sxr[n] = 0; sxi[n] = 0; end
  endtask

  // Drive one group at the falling edge; push the expected response if valid.
  task automatic send(input int k, input bit v, input bit use_given, input exp_t given);
    exp_t e;
    @(negedge clk);
    x0_r = DW'(sxr[0]); x0_i = DW'(sxi[0]);
    x1_r = DW'(sxr[1]); x1_i = DW'(sxi[1]);
    x2_r = DW'(sxr[2]); x2_i = DW'(sxi[2]);
    x3_r = DW'(sxr[3]); x3_i = DW'(sxi[3]);
    lable = 11'(k);
    valid = v;
    if (v) begin
      e = use_given ? given : model(k);
      e.cyc = cyc + 7;
      sb.push_back(e);
    end
  endtask

  // Monitor: ready must match the scoreboard schedule every cycle.
  logic [3:0][OW-1:0] act_r, act_i;
  assign act_r = {y3_r, y2_r, y1_r, y0_r};
  assign act_i = {y3_i, y2_i, y1_i, y0_i};

  always @(negedge clk) begin
    bit   due;
    exp_t e;
    due = (sb.size() > 0) && (sb[0].cyc == cyc);
    chk("ready", longint'(ready), longint'(due));
    if (due) begin
      e = sb.pop_front();
      chk("index", longint'(index), longint'(e.idx));
      for (int m = 0; m < 4; m++) begin
        chk($sformatf("y%0d_r k=%0d", m, e.idx), longint'($signed(act_r[m])), longint'($signed(e.yr[m])));
        chk($sformatf("y%0d_i k=%0d", m, e.idx), longint'($signed(act_i[m])), longint'($signed(e.yi[m])));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, longint'(ready), 0);
    chk({tag, "_index"}, longint'(index), 0);
    chk({tag, "_y0r"}, longint'(y0_r), 0);  chk({tag, "_y0i"}, longint'(y0_i), 0);
    chk({tag, "_y1r"}, longint'(y1_r), 0);  chk({tag, "_y1i"}, longint'(y1_i), 0);
    chk({tag, "_y2r"}, longint'(y2_r), 0);  chk({tag, "_y2i"}, longint'(y2_i), 0);
    chk({tag, "_y3r"}, longint'(y3_r), 0);  chk({tag, "_y3i"}, longint'(y3_i), 0);
  endtask

  initial begin
    exp_t e0;
    zero_x();
    e0.yr = '0; e0.yi = '0; e0.idx = '0; e0.cyc = 0;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: impulse on x0, k=0 -> every bin 32767.
    zero_x(); sxr[0] = 4096;
    e0.yr = {4{27'd32767}}; e0.yi = '0; e0.idx = 11'd0;
    send(0, 1'b1, 1'b1, e0);
    // Directed: impulse on x1, k=0 -> (1, -j, -1, j) * 32767.
    zero_x(); sxr[1] = 4096;
    e0.yr[0] = 27'd32767;       e0.yi[0] = '0;
    e0.yr[1] = '0;              e0.yi[1] = OW'(-32767);
    e0.yr[2] = OW'(-32767);     e0.yi[2] = '0;
    e0.yr[3] = '0;              e0.yi[3] = 27'd32767;
    send(0, 1'b1, 1'b1, e0);
    // Directed: impulse on x2, k=1024 -> twiddle -j.
    zero_x(); sxr[2] = 4096;
    e0.yr = '0;
    e0.yi[0] = OW'(-32767); e0.yi[1] = 27'd32767;
    e0.yi[2] = OW'(-32767); e0.yi[3] = 27'd32767;
    e0.idx = 11'd1024;
    send(1024, 1'b1, 1'b1, e0);
    for (int i = 0; i < 8; i++) begin rand_x(1'b0); send(int'($urandom_range(0, 2047)), 1'b0, 1'b0, e0); end

    // Single-cycle pulse; the monitor rejects any extra ready cycle.
    rand_x(1'b0);
    send(5, 1'b1, 1'b0, e0);
    for (int i = 0; i < 10; i++) begin rand_x(1'b0); send(5, 1'b0, 1'b0, e0); end

    // Full frame: 2048 back-to-back groups, lable = 0..2047.
    for (int i = 0; i < 2048; i++) begin rand_x(1'b0); send(i, 1'b1, 1'b0, e0); end

    // Full-scale inputs to exercise output wrap, including the top labels.
    for (int i = 0; i < 48; i++) begin
      rand_x(1'b1);
      send((i < 8) ? 2047 - i : int'($urandom_range(0, 2047)), 1'b1, 1'b0, e0);
    end

    // Random valid pattern with gaps.
    for (int i = 0; i < 300; i++) begin
      rand_x(1'b0);
      send(int'($urandom_range(0, 2047)), ($urandom_range(0, 9) < 7), 1'b0, e0);
    end

    // Reset while the pipeline is streaming.
    for (int i = 0; i < 10; i++) begin rand_x(1'b0); send(i * 200, 1'b1, 1'b0, e0); end
    @(posedge clk);
    #2;
    chk("pre_reset_ready", longint'(ready), 1);
    rst_n = 1'b0;
    valid = 1'b0;
    sb.delete();
    #1 check_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rand_x(1'b0);
    send(77, 1'b1, 1'b0, e0);
    for (int i = 0; i < 10; i++) begin rand_x(1'b0); send(3, 1'b0, 1'b0, e0); end

    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", longint'(sb.size()), 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/parallel_twiddle_mul_fft4.md
Name: parallel_twiddle_mul_fft4

Overview:
- Final radix-4 stage of an 8192-point FFT built as 2048 x 4.
- Each cycle it takes one group of four complex samples (x0..x3) from the preceding 2048-point FFT stage, plus the group label k (0..2047).
- Multiplies sample n by twiddle W8192^(k*n), performs a 4-point DFT, and emits the four scaled results.
- Fully pipelined: one group per clock, fixed 6-cycle latency.

Parameters:
- DATA_WIDTH, 21: signed width of each input real/imag component.
- TWID_WIDTH, 16: signed width of twiddle components (Q1.(TWID_WIDTH-1)).
- MSB_CUTOFF, 26: top bit kept after scaling; output width = MSB_CUTOFF+1.
- LSB_CUTOFF, 12: number of LSBs discarded (arithmetic shift right) after the butterfly.
- SHIFT, 15: twiddle fixed-point scale, 2^SHIFT represents 1.0.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  1  input group valid this cycle.
- lable  in  11  group label k, unsigned 0..2047.
- x0_r,x0_i,x1_r,x1_i,x2_r,x2_i,x3_r,x3_i  in  DATA_WIDTH each  signed input samples n=0..3.
- y0_r,y0_i,y1_r,y1_i,y2_r,y2_i,y3_r,y3_i  out  MSB_CUTOFF+1 each  signed outputs m=0..3.
- index  out  11  lable delayed to align with y.
- ready  out  1  valid delayed to align with y.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset: all pipeline registers cleared; y*, index and ready = 0.
- Twiddles:
  - Constant table computed at elaboration, covering exponents e = k*n mod 8192 (e <= 6141).
  - w_r = round(cos(2*pi*e/8192) * 2^SHIFT); w_i = -round(sin(2*pi*e/8192) * 2^SHIFT).
  - Each saturated to [-(2^(TWID_WIDTH-1)-1), 2^(TWID_WIDTH-1)-1]; so e=0 gives (32767, 0).
- Stage math, all full precision and signed:
  - p_n = x_n * w_n as a complex multiply (4 real multiplies, 1 add + 1 sub); width DATA_WIDTH+TWID_WIDTH+1.
  - n=0 also goes through the multiplier with w = (32767, 0); no bypass.
  - 4-point DFT: y_m = sum_n p_n * (-j)^(n*m).
  - y0 = p0+p1+p2+p3.
  - y1 = p0 - j*p1 - p2 + j*p3.
  - y2 = p0-p1+p2-p3.
  - y3 = p0 + j*p1 - p2 - j*p3.
  - Butterfly carries 2 extra growth bits.
  - Output = (sum >>> LSB_CUTOFF) bits [MSB_CUTOFF:0]: truncation (floor), wrap, no rounding, no saturation.
- Latency:
  - Inputs sampled at edge E; y*, index and ready are registered and valid after edge E+6.
  - Pipeline split is implementer's choice, but total must be exactly 6.
- Handshake:
  - No backpressure; a new group is accepted every cycle.
  - ready is valid delayed 6 cycles; index is lable delayed 6 cycles.
  - Datapath runs regardless of valid; y values while ready=0 are don't-care.
  - Back-to-back groups produce back-to-back outputs; ready stays high continuously.
- Reset mid-stream: in-flight groups are discarded; ready drops immediately (async); output resumes 6 cycles after the next sampled valid.

Test Plan:
- lable=0, x0_r=4096, all other inputs 0 -> after 6 cycles: y0_r=y1_r=y2_r=y3_r=32767, all y*_i=0; index=0, ready=1.
- lable=0, x1_r=4096, others 0 -> y0=(32767,0), y1=(0,-32767), y2=(-32767,0), y3=(0,32767).
- lable=1024, x2_r=4096, others 0 (twiddle -j) -> y0=(0,-32767), y1=(0,32767), y2=(0,-32767), y3=(0,32767); index=1024.
- Single-cycle valid pulse with lable=5 -> ready high exactly one cycle, 6 cycles later, with index=5; 2048 consecutive groups -> ready high for 2048 consecutive cycles, index 0..2047 in order.
- Full 8192-point frame (2048 groups from a 2048-point FFT stage, lable=i) -> all 8192 outputs (group i, result m at position 4i+m) bit-exact against a fixed-point 8192-point FFT golden model.
- Assert rst_n low while ready=1 -> ready, index and all y* go to 0 immediately; after release, the next input produces output after 6 cycles.
